kt_lowx_mem_responder: RTL and testbench
========================================

Name: kt_lowx_mem_responder

Overview:
Lower-memory responder for the instruction cache's lowX port; it is the far end of the request/response pair the cache drives. It accepts one line-fill request at a time and waits a configurable access latency. It then assembles a BLK_SIZE-bit line from a word-wide backing array, one word per cycle, and returns it with a valid/ready response. It serves as the synthesizable lower-level memory in cache DV benches and as a simple boot memory in integration.

Parameters:
XLEN, 32, backing-array word width in bits
BLK_SIZE, 128, cache line width in bits; WORDS = BLK_SIZE/XLEN (power of 2, >=2)
ADDR_W, 32, request address width
DEPTH, 1024, backing-array depth in words (power of 2)
LATENCY, 4, wait cycles before the first fill beat (0 allowed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
lowx_req_valid_i  in  1  line request valid from cache
lowx_req_ready_o  out  1  responder can accept a request
lowx_req_addr_i  in  ADDR_W  byte address of requested line
lowx_res_valid_o  out  1  line response valid
lowx_res_ready_i  in  1  cache accepts response
lowx_res_blk_o  out  BLK_SIZE  returned line, word 0 in bits [XLEN-1:0]
mem_we_i  in  1  backdoor word write enable (preload/bench)
mem_waddr_i  in  $clog2(DEPTH)  backdoor word index
mem_wdata_i  in  XLEN  backdoor write data
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - State goes to IDLE.
  - lowx_req_ready_o=1 in the first cycle after reset.
  - lowx_res_valid_o=0, lowx_res_blk_o=0, busy_o=0.
  - Backing array is NOT cleared by reset.
- Reset mid-operation: abandons any request with no response. Array contents are retained.
- FSM states: IDLE, WAIT, FILL, RESP.
- IDLE:
  - ready=1.
  - On valid&&ready, capture base word index = (addr >> log2(XLEN/8)) with the low log2(WORDS) bits cleared, modulo DEPTH. Out-of-range addresses wrap.
  - Next state is WAIT with cnt=LATENCY-1, or FILL with beat=0 if LATENCY==0.
- WAIT: cnt decrements each cycle. At cnt==0 go to FILL with beat=0.
- FILL:
  - Array read is combinational (register array).
  - Each cycle without mem_we_i, blk[beat] = array[base+beat] and beat increments.
  - After beat WORDS-1, go to RESP.
  - If mem_we_i is high, the beat stalls for that cycle: the write has priority and no beat is captured.
- RESP:
  - res_valid=1, blk is stable.
  - Hold valid and data until res_ready_i is sampled high, then go to IDLE. lowx_res_valid_o deasserts on the next cycle.
- lowx_req_ready_o=0 in WAIT, FILL and RESP: only one request is outstanding. The next request is accepted in the cycle after the response handshake completes.
- Latency with no backdoor writes: lowx_res_valid_o rises exactly LATENCY+WORDS cycles after the accepting edge. Each stalled FILL cycle adds 1.
- Backdoor writes:
  - Accepted in every state and take effect at the clock edge.
  - A write to a word already captured in FILL does not alter the captured blk. A write to a not-yet-captured word is seen by its later beat.
- Simultaneous events: a request valid in RESP is ignored (ready=0) and must be held by the cache. A response ready outside RESP has no effect.
- lowx_res_blk_o outside RESP holds its last value and is don't-care to the consumer.

Decomposition:
- kt_cache_params gains:
  - localparams WORDS and WORD_IDX_W;
  - the FSM enum lowx_state_e;
  - a lowx_beat_t typedef.
- ilowX_req_t and ilowX_res_t field widths are reused so the bench maps the struct ports onto the flat ports directly.
- Sub-module kt_lowx_word_mem: register array with one write port and one combinational read port; the FSM, counters and line assembly stay in the top module.

Test Plan:
- Preload array[0..3]=0x11111111,0x22222222,0x33333333,0x44444444; request addr 0x0 -> res_valid exactly 8 cycles after accept; blk=0x44444444_33333333_22222222_11111111.
- Request addr 0x0000000C (unaligned) -> same line as addr 0x0 is returned.
- Hold res_ready_i low 5 cycles in RESP -> valid and blk stable for all 5 cycles; req_ready stays 0; a new request is accepted only the cycle after the handshake.
- Backdoor write to word 2 during FILL beat 1 -> beat stalls by one cycle; blk word2 carries the new value; valid rises at cycle 9.
- Request addr = DEPTH*4 + 0x10 -> wraps to word index 4; returns words 4..7.
- Assert rst_i while in WAIT -> the next cycle shows IDLE, ready=1, valid=0; a re-request at addr 0 returns the preloaded data unchanged.

Source files
------------

// File: rtl/kt_cache_params.sv
`default_nettype none
// ============================================================================
// Module   : kt_cache_params (package)
// Brief    : Shared constants, FSM encoding and lowX port structs for the
//            instruction-cache lower-memory interface.
// Revision : 1.0 - initial release
// ============================================================================
package kt_cache_params;

    // Default geometry of the lowX interface
    localparam int LOWX_XLEN     = 32;
    localparam int LOWX_BLK_SIZE = 128;
    localparam int LOWX_ADDR_W   = 32;

    // Words per cache line and the width of a word index within a line
    localparam int WORDS      = LOWX_BLK_SIZE / LOWX_XLEN;
    localparam int WORD_IDX_W = $clog2(WORDS);

    // Responder FSM encoding
    typedef enum logic [1:0] {
        LOWX_IDLE = 2'd0,
        LOWX_WAIT = 2'd1,
        LOWX_FILL = 2'd2,
        LOWX_RESP = 2'd3
    } lowx_state_e;

    // Beat counter within one line fill
    typedef logic [WORD_IDX_W-1:0] lowx_beat_t;

    // Request/response bundles as seen by the cache
    typedef struct packed {
        logic                   valid;
        logic [LOWX_ADDR_W-1:0] addr;
    } ilowX_req_t;

    typedef struct packed {
        logic                     valid;
        logic [LOWX_BLK_SIZE-1:0] blk;
    } ilowX_res_t;

endpackage
`default_nettype wire

// File: rtl/kt_lowx_word_mem.sv
`default_nettype none
// ============================================================================
// Module   : kt_lowx_word_mem
// Brief    : Word-wide register array, one synchronous write port and one
//            combinational read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module kt_lowx_word_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: the written word becomes visible after the clock edge
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/kt_lowx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : kt_lowx_mem_responder
// Brief    : Lower-memory responder for the I-cache lowX port. Accepts one
//            line request, waits LATENCY cycles, gathers the line one word
//            per cycle from a backing array and returns it with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module kt_lowx_mem_responder
    import kt_cache_params::*;
#(
    parameter int XLEN     = LOWX_XLEN,
    parameter int BLK_SIZE = LOWX_BLK_SIZE,
    parameter int ADDR_W   = LOWX_ADDR_W,
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     lowx_req_valid_i,
    output logic                     lowx_req_ready_o,
    input  logic [ADDR_W-1:0]        lowx_req_addr_i,
    output logic                     lowx_res_valid_o,
    input  logic                     lowx_res_ready_i,
    output logic [BLK_SIZE-1:0]      lowx_res_blk_o,
    input  logic                     mem_we_i,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr_i,
    input  logic [XLEN-1:0]          mem_wdata_i,
    output logic                     busy_o
);

    localparam int c_WORDS      = BLK_SIZE / XLEN;
    localparam int c_BEAT_W     = $clog2(c_WORDS);
    localparam int c_IDX_W      = $clog2(DEPTH);
    localparam int c_BYTE_SHIFT = $clog2(XLEN / 8);
    localparam int c_CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD  = (LATENCY > 0) ? c_CNT_W'(LATENCY - 1) : '0;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_WORDS - 1);
    localparam logic [c_IDX_W-1:0]  c_LINE_MASK = c_IDX_W'(c_WORDS - 1);

    lowx_state_e          r_state;
    lowx_state_e          w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BEAT_W-1:0]  r_beat;
    logic [c_IDX_W-1:0]   r_base;
    logic [BLK_SIZE-1:0]  r_blk;

    logic                 w_accept;
    logic                 w_beat_take;
    logic [c_IDX_W-1:0]   w_word_idx;
    logic [c_IDX_W-1:0]   w_line_base;
    logic [c_IDX_W-1:0]   w_raddr;
    logic [XLEN-1:0]      w_rdata;
    logic                 w_unused_addr;

    // Byte address -> line-aligned word index; upper bits drop out so
    // out-of-range addresses wrap around the array.
    assign w_word_idx    = lowx_req_addr_i[c_BYTE_SHIFT +: c_IDX_W];
    assign w_line_base   = w_word_idx & ~c_LINE_MASK;
    assign w_unused_addr = ^lowx_req_addr_i;

    assign w_accept    = (r_state == LOWX_IDLE) && lowx_req_valid_i;
    // A backdoor write owns the cycle; the beat is retried next cycle.
    assign w_beat_take = (r_state == LOWX_FILL) && !mem_we_i;
    assign w_raddr     = r_base + c_IDX_W'(r_beat);

    kt_lowx_word_mem #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .AW    (c_IDX_W)
    ) u_word_mem (
        .clk_i   (clk_i),
        .i_we    (mem_we_i),
        .i_waddr (mem_waddr_i),
        .i_wdata (mem_wdata_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LOWX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOWX_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 0) ? LOWX_FILL : LOWX_WAIT;
                end
            end
            LOWX_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = LOWX_FILL;
                end
            end
            LOWX_FILL: begin
                if (w_beat_take && (r_beat == c_LAST_BEAT)) begin
                    w_next_state = LOWX_RESP;
                end
            end
            LOWX_RESP: begin
                if (lowx_res_ready_i) begin
                    w_next_state = LOWX_IDLE;
                end
            end
            default: w_next_state = LOWX_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        lowx_req_ready_o = 1'b0;
        lowx_res_valid_o = 1'b0;
        busy_o           = 1'b1;
        case (r_state)
            LOWX_IDLE: begin
                lowx_req_ready_o = 1'b1;
                busy_o           = 1'b0;
            end
            LOWX_RESP: lowx_res_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign lowx_res_blk_o = r_blk;

    // Request capture, latency countdown and line assembly
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_beat <= '0;
            r_base <= '0;
            r_blk  <= '0;
        end else begin
            if (w_accept) begin
                r_base <= w_line_base;
                r_cnt  <= c_CNT_LOAD;
                r_beat <= '0;
            end
            if (r_state == LOWX_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_beat_take) begin
                r_blk[r_beat*XLEN +: XLEN] <= w_rdata;
                r_beat                     <= r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kt_lowx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_kt_lowx_mem_responder
// Brief    : Self-checking bench for the lowX line-fill responder. A word
//            array model mirrors every backdoor write; expected lines and
//            response latencies are derived from it arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kt_lowx_mem_responder;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;
    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int LATENCY  = 4;
    localparam int NWORDS   = BLK_SIZE / XLEN;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;
    logic                 res_valid;
    logic                 res_ready;
    logic [BLK_SIZE-1:0]  res_blk;
    logic                 mem_we;
    logic [9:0]           mem_waddr;
    logic [XLEN-1:0]      mem_wdata;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] mem_m [DEPTH];

    kt_lowx_mem_responder #(
        .XLEN     (XLEN),
        .BLK_SIZE (BLK_SIZE),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lowx_req_valid_i (req_valid),
        .lowx_req_ready_o (req_ready),
        .lowx_req_addr_i  (req_addr),
        .lowx_res_valid_o (res_valid),
        .lowx_res_ready_i (res_ready),
        .lowx_res_blk_o   (res_blk),
        .mem_we_i         (mem_we),
        .mem_waddr_i      (mem_waddr),
        .mem_wdata_i      (mem_wdata),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BLK_SIZE-1:0] obs, input logic [BLK_SIZE-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line holding byte address a: word index wraps modulo DEPTH, then
    // rounds down to a multiple of the line size.
    function automatic logic [BLK_SIZE-1:0] line_of(input logic [31:0] a);
        int idx;
        int base;
        idx  = int'(a / 4) % DEPTH;
        base = idx - (idx % NWORDS);
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    task automatic bd_write(input int idx, input logic [XLEN-1:0] data);
        mem_we    = 1'b1;
        mem_waddr = 10'(idx);
        mem_wdata = data;
        @(posedge clk); #1;
        mem_we     = 1'b0;
        mem_m[idx] = data;
    endtask

    // One request/response transaction. wr_edge > 0 places a backdoor write
    // on that clock edge counted from the accepting edge; hold keeps
    // res_ready low for that many cycles in the response phase while a
    // competing request is presented.
    task automatic run_txn(input logic [31:0] addr, input int wr_edge, input int waddr,
                           input logic [XLEN-1:0] wdata, input int hold,
                           input logic [BLK_SIZE-1:0] exp_blk, input int exp_lat,
                           input string tag);
        int n;
        check({tag, "_req_ready"}, BLK_SIZE'(req_ready), BLK_SIZE'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_busy"}, BLK_SIZE'(busy), BLK_SIZE'(1));
        n = 0;
        while (!res_valid && n < 64) begin
            if (n + 1 == wr_edge) begin
                mem_we    = 1'b1;
                mem_waddr = 10'(waddr);
                mem_wdata = wdata;
            end
            @(posedge clk); #1;
            if (mem_we) begin
                mem_m[waddr] = wdata;
                mem_we       = 1'b0;
            end
            n++;
        end
        check({tag, "_latency"}, BLK_SIZE'(n), BLK_SIZE'(exp_lat));
        check({tag, "_blk"}, res_blk, exp_blk);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_addr  = addr ^ 32'h40;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, BLK_SIZE'(res_valid), BLK_SIZE'(1));
            check({tag, "_hold_blk"}, res_blk, exp_blk);
            check({tag, "_hold_req_ready"}, BLK_SIZE'(req_ready), BLK_SIZE'(0));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_post_valid"}, BLK_SIZE'(res_valid), BLK_SIZE'(0));
        check({tag, "_post_ready"}, BLK_SIZE'(req_ready), BLK_SIZE'(1));
        check({tag, "_post_busy"}, BLK_SIZE'(busy), BLK_SIZE'(0));
        req_valid = 1'b0;
    endtask

    initial begin
        logic [BLK_SIZE-1:0] exp;
        logic [31:0]         a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        res_ready = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", BLK_SIZE'(req_ready), BLK_SIZE'(1));
        check("reset_res_valid", BLK_SIZE'(res_valid), BLK_SIZE'(0));
        check("reset_busy", BLK_SIZE'(busy), BLK_SIZE'(0));
        check("reset_blk", res_blk, '0);
        rst = 1'b0;

        // Preload the first 64 words
        bd_write(0, 32'h11111111);
        bd_write(1, 32'h22222222);
        bd_write(2, 32'h33333333);
        bd_write(3, 32'h44444444);
        for (int i = 4; i < 64; i++) begin
            bd_write(i, $urandom);
        end

        // Basic fill of line 0
        run_txn(32'h0, 0, 0, '0, 0,
                128'h44444444_33333333_22222222_11111111, LATENCY + NWORDS, "line0");

        // Unaligned address, response held back for 5 cycles
        run_txn(32'hC, 0, 0, '0, 5, line_of(32'h0), LATENCY + NWORDS, "unaligned_hold");

        // Write to a not-yet-captured word during beat 1 -> stall, new value seen
        exp = line_of(32'h0);
        exp[95:64] = 32'hA5A50002;
        run_txn(32'h0, LATENCY + 2, 2, 32'hA5A50002, 0, exp, LATENCY + NWORDS + 1, "wr_uncaptured");

        // Write to an already-captured word during beat 2 -> stall, old value kept
        exp = line_of(32'h0);
        run_txn(32'h0, LATENCY + 3, 0, 32'hDEAD0000, 0, exp, LATENCY + NWORDS + 1, "wr_captured");

        // Subsequent request sees the updated word 0
        run_txn(32'h4, 0, 0, '0, 0, line_of(32'h0), LATENCY + NWORDS, "after_write");

        // Address beyond the array wraps to word index 4
        run_txn(DEPTH * 4 + 32'h10, 0, 0, '0, 0, line_of(32'h10), LATENCY + NWORDS, "wrap");

        // Reset while waiting abandons the request
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req_ready", BLK_SIZE'(req_ready), BLK_SIZE'(1));
        check("midrst_res_valid", BLK_SIZE'(res_valid), BLK_SIZE'(0));
        check("midrst_busy", BLK_SIZE'(busy), BLK_SIZE'(0));
        run_txn(32'h0, 0, 0, '0, 0, line_of(32'h0), LATENCY + NWORDS, "after_reset");

        // Randomized traffic: idle-time backdoor writes and wrapped addresses
        for (int t = 0; t < 10; t++) begin
            bd_write($urandom_range(0, 63), $urandom);
            a = 32'($urandom_range(0, 7)) * DEPTH * 4
              + 32'($urandom_range(0, 63)) * 4
              + 32'($urandom_range(0, 3));
            run_txn(a, 0, 0, '0, $urandom_range(0, 3), line_of(a), LATENCY + NWORDS, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
